tt_opacc_drain: RTL

- Downstream readout stage for the outer-product accumulator.
- On a drain command it walks the rows of one accumulator mreg through the accumulator's combinational read port (read address out, row data in).
- Rows are streamed out on a valid/ready row interface toward the vector writeback / store path, buffered in a 2-entry FIFO so that backpressure never drops a row.
- It exports busy/mreg status so upstream issue logic can hold off accumulates into the mreg being drained.

---
 rtl/tt_opacc_drain.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/tt_opacc_drain.sv
// Drain stage for the outer-product accumulator. A drain command makes it walk
// the rows of one mreg through the accumulator's combinational read port. Rows
// go through a 2-entry FIFO onto a valid/ready row stream, so a stalled
// consumer never loses a row. busy/mreg status tells upstream issue logic which
// mreg must not be accumulated into while it is being drained.
module tt_opacc_drain #(
    parameter int vl              = 4,
    parameter int ml              = 4,
    parameter int NUM_MREGS       = 2,
    parameter int XLEN            = 64,
    parameter int MREG_ADDR_WIDTH = $clog2(NUM_MREGS),
    parameter int ROW_ADDR_WIDTH  = $clog2(ml),
    parameter int ROW_CNT_WIDTH   = $clog2(ml + 1)
) (
    input  logic                                      i_clk,
    input  logic                                      i_reset,
    input  logic                                      i_cmd_valid,
    output logic                                      o_cmd_ready,
    input  logic [MREG_ADDR_WIDTH-1:0]                i_cmd_mreg,
    input  logic [ROW_CNT_WIDTH-1:0]                  i_cmd_rows,
    output logic [MREG_ADDR_WIDTH+ROW_ADDR_WIDTH-1:0] o_rdaddr,
    input  logic [vl*XLEN-1:0]                        i_rdata,
    output logic                                      o_row_valid,
    input  logic                                      i_row_ready,
    output logic [vl*XLEN-1:0]                        o_row_data,
    output logic [ROW_ADDR_WIDTH-1:0]                 o_row_idx,
    output logic                                      o_row_last,
    output logic                                      o_busy,
    output logic [MREG_ADDR_WIDTH-1:0]                o_busy_mreg
);

    typedef enum logic [1:0] {IDLE, READ, FLUSH} state_e;

    typedef struct packed {
        logic [vl*XLEN-1:0]        data;
        logic [ROW_ADDR_WIDTH-1:0] idx;
        logic                      last;
    } row_t;

    state_e                     state_q, state_d;
    logic [MREG_ADDR_WIDTH-1:0] mreg_q, mreg_d;
    logic [ROW_ADDR_WIDTH-1:0]  row_ptr_q, row_ptr_d;
    logic [ROW_CNT_WIDTH-1:0]   nrows_q, nrows_d;

    row_t [1:0]                 fifo_q, fifo_d;
    logic                       wr_ptr_q, wr_ptr_d;
    logic                       rd_ptr_q, rd_ptr_d;
    logic [1:0]                 count_q, count_d;

    logic                       pop;
    logic                       push;
    logic                       is_last;

    // Handshake and status outputs; forced low during a reset cycle.
    always_comb begin
        o_row_valid = (count_q != 2'd0) && !i_reset;
        o_cmd_ready = (state_q == IDLE) && !i_reset;
        o_busy      = ((state_q != IDLE) || (count_q != 2'd0)) && !i_reset;
        o_busy_mreg = mreg_q;
        // The row pointer stops on the last row, so the address holds outside READ.
        o_rdaddr    = {mreg_q, row_ptr_q};
        o_row_data  = fifo_q[rd_ptr_q].data;
        o_row_idx   = fifo_q[rd_ptr_q].idx;
        o_row_last  = fifo_q[rd_ptr_q].last;
        pop         = o_row_valid && i_row_ready;
        // A full FIFO can still take a row in a cycle where it is also popped.
        push        = (state_q == READ) && ((count_q != 2'd2) || pop);
        is_last     = (ROW_CNT_WIDTH'(row_ptr_q) == (nrows_q - ROW_CNT_WIDTH'(1)));
    end

    // Command sequencing: accept, walk the rows, then wait for the FIFO to drain.
    always_comb begin
        state_d   = state_q;
        mreg_d    = mreg_q;
        row_ptr_d = row_ptr_q;
        nrows_d   = nrows_q;
        unique case (state_q)
            IDLE: begin
                if (i_cmd_valid) begin
                    mreg_d    = i_cmd_mreg;
                    row_ptr_d = '0;
                    if ((i_cmd_rows == '0) || (i_cmd_rows > ROW_CNT_WIDTH'(ml)))
                        nrows_d = ROW_CNT_WIDTH'(ml);
                    else
                        nrows_d = i_cmd_rows;
                    state_d = READ;
                end
            end
            READ: begin
                if (push) begin
                    if (is_last) state_d = FLUSH;
                    else         row_ptr_d = row_ptr_q + ROW_ADDR_WIDTH'(1);
                end
            end
            FLUSH: begin
                if (count_d == 2'd0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Two-entry circular FIFO; the entry at rd_ptr is the registered output.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q].data = i_rdata;
            fifo_d[wr_ptr_q].idx  = row_ptr_q;
            fifo_d[wr_ptr_q].last = is_last;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    // State registers; a reset drops all queued rows.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            mreg_q    <= '0;
            row_ptr_q <= '0;
            nrows_q   <= '0;
            fifo_q    <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            mreg_q    <= mreg_d;
            row_ptr_q <= row_ptr_d;
            nrows_q   <= nrows_d;
            fifo_q    <= fifo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

endmodule
